// File: rtl/nn_pkg.sv
// Shared types for the nn_io_sequencer block: the host-side handshake FSM states.
package nn_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        REQ   = 2'd1,
        REL   = 2'd2,
        DRAIN = 2'd3
    } nn_io_state_e;

endpackage

// File: rtl/nn_out_ram.sv
// Output activation storage: one network-facing write/read port with a registered read,
// plus a registered drain read port. Out-of-range writes are dropped and reads return 0.
module nn_out_ram #(
    parameter int Depth     = 4,
    parameter int DataWidth = 8,
    parameter int AddrWidth = 6,
    parameter int IdxWidth  = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 wr_en_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wr_data_i,
    output logic [DataWidth-1:0] rd_data_o,
    input  logic [IdxWidth-1:0]  drain_addr_i,
    output logic [DataWidth-1:0] drain_data_o
);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] rd_mux;
    logic [DataWidth-1:0] drain_mux;
    logic [DataWidth-1:0] rd_q;
    logic [DataWidth-1:0] drain_q;

    // Address decode by comparison, so addresses beyond Depth match no entry.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (wr_en_i && (addr_i == AddrWidth'(i))) begin
                    mem_q[i] <= wr_data_i;
                end
            end
        end
    end

    always_comb begin
        rd_mux    = '0;
        drain_mux = '0;
        for (int i = 0; i < Depth; i++) begin
            if (addr_i == AddrWidth'(i)) begin
                rd_mux = mem_q[i];
            end
            if (drain_addr_i == IdxWidth'(i)) begin
                drain_mux = mem_q[i];
            end
        end
    end

    // Reads sample the pre-write contents, so a same-cycle read/write returns old data.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_q    <= '0;
            drain_q <= '0;
        end else begin
            rd_q    <= rd_mux;
            drain_q <= drain_mux;
        end
    end

    assign rd_data_o    = rd_q;
    assign drain_data_o = drain_q;

endmodule

// File: rtl/nn_io_sequencer.sv
// Host-side sequencer: loads the network input RAM, runs the 4-phase req/ack handshake,
// serves the network's output RAM and streams the results. Optional argmax: NN_IO_ARGMAX_EN.
module nn_io_sequencer
    import nn_pkg::*;
#(
    parameter int  InputWidth     = 49,
    parameter int  NumOutputLayer = 4,
    parameter int  DataWidth      = 8,
    parameter int  AddrWidth      = $clog2(InputWidth),
    localparam int OutIdxWidth    = (NumOutputLayer > 1) ? $clog2(NumOutputLayer) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DataWidth-1:0] in_data_i,
    output logic                 nn_req_o,
    input  logic                 nn_ack_i,
    output logic                 actv_in_ram_we_o,
    output logic [AddrWidth-1:0] actv_in_ram_addr_o,
    output logic [DataWidth-1:0] actv_in_ram_din_o,
    input  logic [AddrWidth-1:0] actv_out_ram_addr_i,
    input  logic                 actv_out_ram_we_i,
    input  logic [DataWidth-1:0] actv_out_ram_din_i,
    output logic [DataWidth-1:0] actv_out_ram_dout_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] out_data_o,
    output logic                 out_last_o,
    output logic                 busy_o
`ifdef NN_IO_ARGMAX_EN
    ,
    output logic [OutIdxWidth-1:0] class_o,
    output logic                   class_valid_o
`endif
);

    localparam logic [AddrWidth-1:0]   LoadLast  = AddrWidth'(InputWidth - 1);
    localparam logic [OutIdxWidth-1:0] DrainLast = OutIdxWidth'(NumOutputLayer - 1);

    nn_io_state_e           state_q, state_d;
    logic [AddrWidth-1:0]   load_cnt_q, load_cnt_d;
    logic [OutIdxWidth-1:0] drain_cnt_q, drain_cnt_d;
    logic                   in_fire;
    logic                   out_fire;
    logic [DataWidth-1:0]   drain_word;

    assign in_ready_o = (state_q == LOAD);
    assign in_fire    = in_valid_i && in_ready_o;
    assign out_fire   = out_valid_o && out_ready_i;

    // Handshake-driven outputs are decoded straight from the state register.
    assign nn_req_o           = (state_q == REQ);
    assign busy_o             = (state_q != LOAD);
    assign out_valid_o        = (state_q == DRAIN);
    assign out_last_o         = out_valid_o && (drain_cnt_q == DrainLast);
    assign out_data_o         = out_valid_o ? drain_word : '0;
    assign actv_in_ram_we_o   = in_fire;
    assign actv_in_ram_addr_o = load_cnt_q;
    assign actv_in_ram_din_o  = in_fire ? in_data_i : '0;

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            LOAD: begin
                if (in_fire) begin
                    if (load_cnt_q == LoadLast) begin
                        load_cnt_d = '0;
                        state_d    = REQ;
                    end else begin
                        load_cnt_d = load_cnt_q + 1'b1;
                    end
                end
            end
            REQ: begin
                if (nn_ack_i) begin
                    state_d = REL;
                end
            end
            REL: begin
                if (!nn_ack_i) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    if (drain_cnt_q == DrainLast) begin
                        drain_cnt_d = '0;
                        state_d     = LOAD;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= LOAD;
            load_cnt_q  <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Drain port is addressed with the next index so the word is ready when DRAIN shows it.
    nn_out_ram #(
        .Depth    (NumOutputLayer),
        .DataWidth(DataWidth),
        .AddrWidth(AddrWidth),
        .IdxWidth (OutIdxWidth)
    ) u_out_ram (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .wr_en_i     (actv_out_ram_we_i),
        .addr_i      (actv_out_ram_addr_i),
        .wr_data_i   (actv_out_ram_din_i),
        .rd_data_o   (actv_out_ram_dout_o),
        .drain_addr_i(drain_cnt_d),
        .drain_data_o(drain_word)
    );

`ifdef NN_IO_ARGMAX_EN
    logic signed [DataWidth-1:0] max_q;
    logic [OutIdxWidth-1:0]      max_idx_q;
    logic [OutIdxWidth-1:0]      class_q;
    logic                        class_valid_q;
    logic                        take_new;
    logic [OutIdxWidth-1:0]      best_idx;

    // Strict greater-than keeps the lowest index on ties.
    assign take_new = (drain_cnt_q == '0) || ($signed(drain_word) > max_q);
    assign best_idx = take_new ? drain_cnt_q : max_idx_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            max_q         <= '0;
            max_idx_q     <= '0;
            class_q       <= '0;
            class_valid_q <= 1'b0;
        end else begin
            class_valid_q <= out_fire && out_last_o;
            if (out_fire) begin
                if (take_new) begin
                    max_q <= $signed(drain_word);
                end
                max_idx_q <= best_idx;
                if (out_last_o) begin
                    class_q <= best_idx;
                end
            end
        end
    end

    assign class_o       = class_q;
    assign class_valid_o = class_valid_q;
`endif

endmodule

// File: tb/tb_nn_io_sequencer.sv
// Self-checking bench for nn_io_sequencer: directed table-driven network accesses plus
// randomized inferences checked against a simple array model of the output storage.
module tb_nn_io_sequencer;

    localparam int IW = 4;
    localparam int NO = 4;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int OW = 2;

    logic          clk;
    logic          reset_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          nn_req_o;
    logic          nn_ack_i;
    logic          actv_in_ram_we_o;
    logic [AW-1:0] actv_in_ram_addr_o;
    logic [DW-1:0] actv_in_ram_din_o;
    logic [AW-1:0] actv_out_ram_addr_i;
    logic          actv_out_ram_we_i;
    logic [DW-1:0] actv_out_ram_din_i;
    logic [DW-1:0] actv_out_ram_dout_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic          out_last_o;
    logic          busy_o;
`ifdef NN_IO_ARGMAX_EN
    logic [OW-1:0] class_o;
    logic          class_valid_o;
`endif

    nn_io_sequencer #(
        .InputWidth    (IW),
        .NumOutputLayer(NO),
        .DataWidth     (DW),
        .AddrWidth     (AW)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset_i),
        .in_valid_i         (in_valid_i),
        .in_ready_o         (in_ready_o),
        .in_data_i          (in_data_i),
        .nn_req_o           (nn_req_o),
        .nn_ack_i           (nn_ack_i),
        .actv_in_ram_we_o   (actv_in_ram_we_o),
        .actv_in_ram_addr_o (actv_in_ram_addr_o),
        .actv_in_ram_din_o  (actv_in_ram_din_o),
        .actv_out_ram_addr_i(actv_out_ram_addr_i),
        .actv_out_ram_we_i  (actv_out_ram_we_i),
        .actv_out_ram_din_i (actv_out_ram_din_i),
        .actv_out_ram_dout_o(actv_out_ram_dout_o),
        .out_valid_o        (out_valid_o),
        .out_ready_i        (out_ready_i),
        .out_data_o         (out_data_o),
        .out_last_o         (out_last_o),
        .busy_o             (busy_o)
`ifdef NN_IO_ARGMAX_EN
        ,
        .class_o            (class_o),
        .class_valid_o      (class_valid_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [DW-1:0] exp_dout;
    } net_row_t;

    net_row_t      net_tbl [9];
    logic [DW-1:0] in_words [IW];
    logic [DW-1:0] model_mem [NO];
    int            n_vec;
    int            n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NO; i++) model_mem[i] = '0;
    endtask

    // Streams in_words; starts and ends just after a falling edge, ending in REQ.
    task automatic do_load();
        for (int i = 0; i < IW; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = in_words[i];
            #1;
            chk("load_ready", in_ready_o, 1);
            chk("load_we", actv_in_ram_we_o, 1);
            chk("load_addr", actv_in_ram_addr_o, i);
            chk("load_din", actv_in_ram_din_o, in_words[i]);
            @(negedge clk);
        end
        in_data_i = 8'hEE;
        #1;
        chk("req_raised", nn_req_o, 1);
        chk("req_backpressure", in_ready_o, 0);
        chk("req_no_we", actv_in_ram_we_o, 0);
        chk("req_busy", busy_o, 1);
        @(negedge clk);
        in_valid_i = 1'b0;
    endtask

    // One network access; expected read data is the storage content before this write.
    task automatic net_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
        logic [DW-1:0] exp;
        exp = (int'(addr) < NO) ? model_mem[int'(addr)] : '0;
        if (we && int'(addr) < NO) model_mem[int'(addr)] = din;
        actv_out_ram_we_i   = we;
        actv_out_ram_addr_i = addr;
        actv_out_ram_din_i  = din;
        @(negedge clk);
        chk("net_dout", actv_out_ram_dout_o, exp);
        actv_out_ram_we_i = 1'b0;
    endtask

    task automatic do_handshake(input int pad);
        repeat (pad) @(negedge clk);
        chk("req_held", nn_req_o, 1);
        nn_ack_i = 1'b1;
        @(negedge clk);
        chk("req_dropped", nn_req_o, 0);
        chk("rel_no_valid", out_valid_o, 0);
        @(negedge clk);
        chk("rel_wait", out_valid_o, 0);
        chk("rel_busy", busy_o, 1);
        nn_ack_i = 1'b0;
        @(negedge clk);
        chk("drain_start", out_valid_o, 1);
    endtask

    task automatic do_drain(input int stall_idx, input int stall_len);
        logic [DW-1:0] exp_w [NO];
        int            best;
        for (int k = 0; k < NO; k++) exp_w[k] = model_mem[k];
        best = 0;
        for (int k = 1; k < NO; k++) begin
            if ($signed(exp_w[k]) > $signed(exp_w[best])) best = k;
        end
        for (int k = 0; k < NO; k++) begin
            if (k == stall_idx) begin
                out_ready_i = 1'b0;
                repeat (stall_len) begin
                    #1;
                    chk("stall_valid", out_valid_o, 1);
                    chk("stall_data", out_data_o, exp_w[k]);
                    @(negedge clk);
                end
            end
            out_ready_i = 1'b1;
            #1;
            chk("drain_valid", out_valid_o, 1);
            chk("drain_data", out_data_o, exp_w[k]);
            chk("drain_last", out_last_o, (k == NO - 1) ? 1 : 0);
            @(negedge clk);
        end
        out_ready_i = 1'b0;
        #1;
        chk("done_busy", busy_o, 0);
        chk("done_ready", in_ready_o, 1);
        chk("done_valid", out_valid_o, 0);
`ifdef NN_IO_ARGMAX_EN
        chk("class_valid_pulse", class_valid_o, 1);
        chk("class", class_o, best);
        @(negedge clk);
        chk("class_valid_drop", class_valid_o, 0);
`else
        @(negedge clk);
`endif
        $display("drain: %02h %02h %02h %02h argmax=%0d", exp_w[0], exp_w[1], exp_w[2], exp_w[3], best);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        net_tbl[0] = '{1'b1, 3'd0, 8'h05, 8'h00};
        net_tbl[1] = '{1'b1, 3'd1, 8'hF0, 8'h00};
        net_tbl[2] = '{1'b1, 3'd2, 8'h7F, 8'h00};
        net_tbl[3] = '{1'b1, 3'd3, 8'h01, 8'h00};
        net_tbl[4] = '{1'b1, 3'd6, 8'hAA, 8'h00};
        net_tbl[5] = '{1'b0, 3'd2, 8'h00, 8'h7F};
        net_tbl[6] = '{1'b0, 3'd6, 8'h00, 8'h00};
        net_tbl[7] = '{1'b0, 3'd0, 8'h00, 8'h05};
        net_tbl[8] = '{1'b1, 3'd1, 8'hF0, 8'hF0};

        reset_i             = 1'b1;
        in_valid_i          = 1'b0;
        in_data_i           = '0;
        nn_ack_i            = 1'b0;
        actv_out_ram_addr_i = '0;
        actv_out_ram_we_i   = 1'b0;
        actv_out_ram_din_i  = '0;
        out_ready_i         = 1'b0;
        clear_model();
        #1;
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_req", nn_req_o, 0);
        chk("rst_valid", out_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_dout", actv_out_ram_dout_o, 0);
        chk("rst_we", actv_in_ram_we_o, 0);
        repeat (2) @(negedge clk);
        reset_i = 1'b0;

        // Inference 1: directed table of network accesses, stalled drain.
        in_words[0] = 8'h11; in_words[1] = 8'h22; in_words[2] = 8'h33; in_words[3] = 8'h44;
        do_load();
        for (int r = 0; r < 9; r++) begin
            actv_out_ram_we_i   = net_tbl[r].we;
            actv_out_ram_addr_i = net_tbl[r].addr;
            actv_out_ram_din_i  = net_tbl[r].din;
            if (net_tbl[r].we && int'(net_tbl[r].addr) < NO)
                model_mem[int'(net_tbl[r].addr)] = net_tbl[r].din;
            @(negedge clk);
            chk("tbl_dout", actv_out_ram_dout_o, net_tbl[r].exp_dout);
            actv_out_ram_we_i = 1'b0;
        end
        do_handshake(0);
        do_drain(2, 5);

        // Acknowledge while idle must not start anything.
        nn_ack_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ack_busy", busy_o, 0);
        chk("idle_ack_req", nn_req_o, 0);
        nn_ack_i = 1'b0;
        @(negedge clk);

        // Inference 2: tied maximum, plus a same-cycle read/write returning old data.
        for (int i = 0; i < IW; i++) in_words[i] = 8'($urandom);
        do_load();
        net_access(1'b1, 3'd3, 8'h7F);
        net_access(1'b1, 3'd3, 8'h7F);
        net_access(1'b0, 3'd3, 8'h00);
        do_handshake(3);
        do_drain(-1, 0);

        // Reset mid-inference while the request is up.
        for (int i = 0; i < IW; i++) in_words[i] = 8'($urandom);
        do_load();
        #2;
        reset_i = 1'b1;
        #1;
        chk("abort_req", nn_req_o, 0);
        chk("abort_ready", in_ready_o, 1);
        clear_model();
        @(negedge clk);
        reset_i = 1'b0;
        $display("reset abort in REQ");

        // Randomized inferences.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < IW; i++) in_words[i] = 8'($urandom);
            do_load();
            for (int a = 0; a < int'($urandom_range(3, 8)); a++) begin
                net_access(1'($urandom), AW'($urandom_range(0, 7)), 8'($urandom));
            end
            do_handshake(int'($urandom_range(0, 4)));
            do_drain(int'($urandom_range(0, NO)), int'($urandom_range(1, 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nn_io_sequencer.md
Name: nn_io_sequencer

Overview:
- Host-side counterpart of the network top: the initiator of its req/ack handshake and the responder that owns its output activation RAM.
- Accepts an input vector from a valid/ready stream and writes it into the network's input activation RAM port.
- Raises the request and waits for the acknowledge. Serves the network's output-RAM accesses from local storage, then streams the results out.
- Sits between the network top and the system datapath or DMA.

Parameters:
- InputWidth, 49, number of input activations per inference.
- NumOutputLayer, 4, number of output activations captured and streamed.
- DataWidth, 8, activation word width (signed fixed point).
- AddrWidth, $clog2(InputWidth), activation RAM address width; must match the network top.
- localparam OutIdxWidth = $clog2(NumOutputLayer) (minimum 1).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous active-high reset.
- in_valid_i  in  1  input stream word valid.
- in_ready_o  out  1  input stream ready.
- in_data_i  in  DataWidth  input activation word.
- nn_req_o  out  1  inference request to the network.
- nn_ack_i  in  1  inference acknowledge from the network.
- actv_in_ram_we_o  out  1  write enable into the network input RAM.
- actv_in_ram_addr_o  out  AddrWidth  network input RAM address.
- actv_in_ram_din_o  out  DataWidth  write data into the network input RAM.
- actv_out_ram_addr_i  in  AddrWidth  network output-RAM address (network is the initiator).
- actv_out_ram_we_i  in  1  network output-RAM write enable.
- actv_out_ram_din_i  in  DataWidth  write data from the network.
- actv_out_ram_dout_o  out  DataWidth  read data returned to the network.
- out_valid_o  out  1  result stream valid.
- out_ready_i  in  1  result stream ready.
- out_data_o  out  DataWidth  result activation.
- out_last_o  out  1  marks the final result word.
- busy_o  out  1  high in any state other than LOAD.

Behaviour:
- Clock and reset: one clock, clk_i; reset_i is asynchronous, active-high.
- Reset values: all outputs 0 except in_ready_o = 1. State = LOAD, counters = 0, output storage = 0.
- FSM states: LOAD, REQ, REL, DRAIN.
- LOAD:
  - in_ready_o = 1.
  - On in_valid_i && in_ready_o, in the same cycle: actv_in_ram_we_o = 1, actv_in_ram_addr_o = load_cnt, actv_in_ram_din_o = in_data_i. These are combinational from the handshake; there is no added latency.
  - load_cnt increments on each accepted word. When the word at InputWidth-1 is accepted, load_cnt goes to 0 and the FSM moves to REQ.
- REQ:
  - nn_req_o = 1 (registered) and held until nn_ack_i = 1 is sampled.
  - On that sample: nn_req_o drops next cycle, FSM moves to REL.
  - in_ready_o = 0 in REQ, REL and DRAIN.
- REL: wait for nn_ack_i = 0 (4-phase release), then move to DRAIN with drain_cnt = 0.
- Output RAM responder, active in every state:
  - Write: actv_out_ram_we_i with addr < NumOutputLayer writes mem[addr] at the clock edge. Writes to addr >= NumOutputLayer are ignored.
  - Read: actv_out_ram_dout_o = mem[addr] registered, 1-cycle latency. Out-of-range reads return 0.
  - Same-cycle read and write to one address returns the old data.
- DRAIN:
  - out_valid_o = 1, out_data_o = mem[drain_cnt], out_last_o = (drain_cnt == NumOutputLayer-1).
  - Each out_valid_o && out_ready_i beat advances drain_cnt.
  - The final beat returns the FSM to LOAD.
  - out_data_o is stable while stalled.
- Protocol rules:
  - nn_ack_i high in LOAD is ignored; no spurious transition.
  - in_valid_i outside LOAD is back-pressured, never dropped.
  - Reset asserted mid-inference aborts immediately to the reset state; nn_req_o falls asynchronously.
- Width rules: counters are AddrWidth / OutIdxWidth wide; no arithmetic on data.

Optional Feature:
- Macro: NN_IO_ARGMAX_EN.
- When defined:
  - Adds output port class_o [OutIdxWidth-1:0] and class_valid_o (1).
  - During DRAIN, a running signed maximum over the streamed words is tracked. Ties keep the lowest index.
  - class_o is updated on the out_last_o beat; class_valid_o pulses high for one cycle the cycle after that beat.
  - Both are reset to 0.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package nn_pkg: state enum nn_io_state_e {LOAD, REQ, REL, DRAIN}.
- Sub-module nn_out_ram (NumOutputLayer x DataWidth, 1 write port / 1 registered read port) holds the output storage. The FSM and counters live in the top.

Test Plan:
- InputWidth=4, NumOutputLayer=4, DataWidth=8; stream 0x11,0x22,0x33,0x44 → input RAM writes at addr 0..3 with that data, then nn_req_o=1 the next cycle.
- Network model acks after 10 cycles, writes 0x05,0xF0,0x7F,0x01 to addr 0..3, then drops ack → nn_req_o falls the cycle after ack; stream out 05,F0,7F,01 with out_last_o on 01.
- out_ready_i held low 5 cycles mid-drain → out_data_o stable; no word lost or duplicated.
- Network writes addr 6 (out of range) and reads addr 2 → no storage change; dout = stored value one cycle later; a read of addr 6 returns 0.
- reset_i pulsed while in REQ → nn_req_o=0 immediately, in_ready_o=1, a fresh load starts at addr 0.
- NN_IO_ARGMAX_EN defined, results 05,F0,7F,7F → class_o=2, class_valid_o pulses once.
